// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit with byte-lane alignment and a valid/ready memory port.
// Optional build macro NPC_LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module npc_lsu #(
  parameter int XLEN = 64,
  parameter int NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [NB-1:0]   mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata
);

  // state | meaning
  // IDLE  | ready for a new op
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for mem_rsp_valid
  // RESP  | one-cycle completion pulse
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic [1:0]      sz;
  logic [XLEN-1:0] size_low;
  logic [XLEN-1:0] addr_al;
  logic [OW-1:0]   off;
  logic [NB-1:0]   lanes;
  logic [NB-1:0]   lanes_sh;
  logic [XLEN-1:0] byte_bits;
  logic [XLEN-1:0] wdata_sh;
  logic            illegal;

  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] ld_bits;
  logic            sign;
  logic [XLEN-1:0] ext;

  assign sz = req_funct3[1:0];

  always_comb begin
    lanes = '0;
    for (int i = 0; i < NB; i++)
      if (32'(i) < (32'd1 << sz)) lanes[i] = 1'b1;
    byte_bits = '0;
    for (int i = 0; i < XLEN; i++)
      byte_bits[i] = lanes[i/8];
    size_low = XLEN'((32'd1 << sz) - 32'd1);
    // Without the trap build, misaligned addresses are silently rounded down to the access size.
    addr_al  = req_addr & ~size_low;
    off      = addr_al[OW-1:0];
    lanes_sh = lanes << off;
    wdata_sh = (req_wdata & byte_bits) << {off, 3'b000};
    illegal  = (req_wen && req_funct3[2]) ||
               (!req_wen && req_funct3 == 3'b111) ||
               (XLEN == 32 && sz == 2'd3);
`ifdef NPC_LSU_MISALIGN_TRAP_EN
    if (|(req_addr & size_low)) illegal = 1'b1;
`endif
  end

  always_comb begin
    raw     = mem_rsp_rdata >> {off_q, 3'b000};
    ld_bits = '0;
    sign    = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (32'(i) < (32'd8 << f3_q[1:0])) ld_bits[i] = 1'b1;
      if (32'(i) == (32'd8 << f3_q[1:0]) - 32'd1) sign = raw[i];
    end
    ext = (raw & ld_bits) | ((sign && !f3_q[2]) ? ~ld_bits : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = illegal ? RESP : REQ;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_rsp_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign resp_valid    = (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q          <= '0;
      off_q         <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        f3_q          <= req_funct3;
        off_q         <= off;
        mem_req_wen   <= req_wen;
        mem_req_addr  <= addr_al & ~XLEN'(NB - 1);
        mem_req_wdata <= req_wen ? wdata_sh : '0;
        mem_req_wmask <= req_wen ? lanes_sh : '0;
        resp_err      <= illegal;
        resp_rdata    <= '0;
      end
      if (state_q == WAIT && mem_rsp_valid && !mem_req_wen)
        resp_rdata <= ext;
    end
  end

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Multi-cycle load/store unit for the npc core; replaces the single-cycle, store-doubleword-only memory path.
- Accepts one load or store per request from the execute stage and performs byte-lane alignment and write-mask generation.
- Drives a valid/ready request/response memory port (backed by the pmem DPI model or a bus bridge) and returns sign- or zero-extended load data.
- Parametrised in data width, supports every RV64I load/store size, and keeps one transaction in flight.

Parameters:
- XLEN, 64: data and address width; legal values 32 or 64.
- NB, XLEN/8: bytes per memory beat (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  unit idle, able to accept.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/signedness).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data (0 for stores).
- resp_err  out  1  access illegal (see Behaviour / Optional Feature).
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  XLEN  beat-aligned address (low log2(NB) bits zero).
- mem_req_wdata  out  XLEN  lane-shifted store data.
- mem_req_wmask  out  NB  byte write mask (0 for loads).
- mem_rsp_valid  in  1  read data / write acknowledge.
- mem_rsp_rdata  in  XLEN  full beat read data.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, mem_req_valid and mem_req_wen = 0; resp_rdata, mem_req_addr, mem_req_wdata and mem_req_wmask = 0.
  - Reset mid-transaction abandons it; mem_req_valid drops asynchronously, and no resp_valid is ever produced for the aborted op.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, latch wen/funct3/addr/wdata. Go to REQ, or to RESP with err = 1 if the access is illegal (no memory access is issued).
  - REQ: mem_req_valid = 1, with all mem_req_* fields held stable until mem_req_ready. On handshake go to WAIT.
  - WAIT: mem_rsp_valid is sampled only here. On mem_rsp_valid, capture the extended data (loads) and go to RESP. A store completes on mem_rsp_valid; its rdata is ignored.
  - RESP: resp_valid = 1 for exactly one cycle with resp_rdata/resp_err; return to IDLE. There is no response backpressure.
- mem_rsp_valid seen in IDLE/REQ/RESP (stale, e.g. after reset) is ignored.
- Latency: accept at cycle N, mem_req_valid at N+1. With zero-wait memory (ready at N+1, rsp at N+2), resp_valid is at N+3. Throughput is 1 op per 4 cycles minimum.
- Size from funct3[1:0]: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B. funct3[2] = 1 means unsigned (loads only).
- Illegal access, always resp_err:
  - store with funct3[2] = 1;
  - load funct3 = 3'b111;
  - size 8 B when XLEN = 32.
- Lane handling: off = addr[log2(NB)-1:0].
  - wmask = ((1<<size)-1) << off.
  - wdata = req_wdata << (8*off); bytes outside the mask are don't-care, but the bench expects them as 0.
  - Load: raw = mem_rsp_rdata >> (8*off), truncated to size, then sign-extended (funct3[2] = 0) or zero-extended (funct3[2] = 1) to XLEN.
  - Lanes never wrap past the beat; see Optional Feature.
- Simultaneous req_valid while busy: req_ready = 0, so the request is not accepted and the requester holds it.

Optional Feature:
- Macro NPC_LSU_MISALIGN_TRAP_EN.
- Defined: an access with (addr mod size) != 0 sets resp_err = 1, returns via RESP one cycle after accept, and issues no memory request; resp_rdata = 0.
- Undefined: the misaligned address is force-aligned by clearing addr bits below the size, then processed as a normal access; resp_err is never set for alignment.

Test Plan:
- XLEN = 64, store SD, addr 0x80000008, wdata 0x1122334455667788, zero-wait memory:
  - mem_req_addr = 0x80000008, wmask = 0xFF, wdata unchanged;
  - resp_valid 3 cycles after accept, resp_err = 0.
- Load LB, addr 0x80000003, mem_rsp_rdata = 0x00000000_80FF0000:
  - byte 0x80 → resp_rdata = 0xFFFFFFFFFFFFFF80.
  - Same with LBU → 0x0000000000000080.
- Store SH, addr 0x80000006, wdata 0xABCD → wmask = 0xC0, mem_req_wdata = 0xABCD000000000000.
- mem_req_ready held low 5 cycles, then mem_rsp_valid delayed 3 cycles:
  - mem_req_* stable throughout; req_ready = 0 until after the resp_valid cycle;
  - a second req_valid during busy is accepted only after return to IDLE.
- LW at addr 0x80000002:
  - with NPC_LSU_MISALIGN_TRAP_EN: resp_err = 1 one cycle after accept, mem_req_valid never asserted;
  - without it: mem access at 0x80000000 lanes 0-3.
- Assert rst while in WAIT:
  - mem_req_valid and resp_valid = 0 immediately; a later mem_rsp_valid is ignored;
  - the next LD completes normally with correct data.
